rng_arbiter: RTL and testbench
==============================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter SEED_TIMEOUT, default 256, cycles spent in SEED before forced entry to RUN.
REQ-003 SHALL have port clk_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port random_num  input  32  software-written seed word from the platform PIO.
REQ-006 SHALL have port req  input  N_REQ  per-requester level request, held until acked.
REQ-007 SHALL have port ack  output  N_REQ  registered one-hot one-cycle grant pulse.
REQ-008 SHALL have port rnd_out  output  32  random word; valid only in the cycle ack is nonzero.
REQ-009 SHALL have port ready  output  1  high while the FSM is in RUN.
REQ-010 SHALL have port grant_cnt  output  16  total grants issued, for hex display.

Function
REQ-011 SHALL keep a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), stepping every cycle.
REQ-012 SHALL register random_num into prev_seed every cycle; random_num != prev_seed is a reseed event.
REQ-013 On a reseed event, lfsr SHALL load random_num next cycle, or 32'hACE1_2468 if random_num is zero; reseed overrides stepping.
REQ-014 FSM SHALL have states SEED and RUN; reset enters SEED.
REQ-015 SEED -> RUN SHALL occur on the first reseed event with nonzero random_num, or when a 16-bit wait counter reaches SEED_TIMEOUT-1.
REQ-016 In SEED, ack SHALL stay zero and requests SHALL remain pending; RUN persists until reset.
REQ-017 In RUN, eligible = req & ~ack (the requester acked this cycle is masked, preventing a double grant on held req).
REQ-018 Arbitration SHALL be round-robin: search starts at index ptr, wrapping modulo N_REQ; the first eligible index wins.
REQ-019 On a grant to index i, the next cycle SHALL have ack = one-hot(i), rnd_out = lfsr ^ random_num (values sampled in the granting cycle), and ptr = (i+1) mod N_REQ.
REQ-020 With no eligible requester, ack SHALL be zero and ptr and rnd_out SHALL hold.
REQ-021 Latency SHALL be one cycle from req sampled high (uncontended, RUN) to ack; at most one grant per cycle.
REQ-022 A requester holding req after ack SHALL be re-granted only after every other pending requester is served once.
REQ-023 grant_cnt SHALL increment by 1 per ack and wrap 16'hFFFF -> 0.
REQ-024 A reseed and a grant in the same cycle SHALL deliver the pre-reseed lfsr XOR current random_num.
REQ-025 A req that drops before being granted SHALL be silently withdrawn.

Reset
REQ-026 Asynchronous assertion SHALL force: state=SEED, ack=0, rnd_out=0, ready=0, grant_cnt=0, ptr=0, wait counter=0, lfsr=32'hACE1_2468, prev_seed=0.
REQ-027 Reset mid-grant SHALL clear ack immediately; no ack SHALL appear until after RUN re-entry.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, LFSR mask 32'h8020_0003, and default seed 32'hACE1_2468.
REQ-029 Round-robin selection SHALL be one sub-module, rr_pick (inputs: eligible vector, ptr; outputs: valid, index).

Verification
REQ-030 Reset, random_num=0 held -> ready rises after exactly 256 cycles; ack=0 throughout.
REQ-031 In SEED, write random_num=32'h1234_5678 -> ready=1 one cycle after the reseed load; lfsr=32'h1234_5678 in that cycle.
REQ-032 RUN, ptr=0, req=4'b1111 held -> ack sequence 0001,0010,0100,1000,0001; grant_cnt +1 per cycle.
REQ-033 RUN, req=4'b0100 only, held one cycle -> ack=0100 next cycle, then zero; rnd_out equals the model lfsr XOR random_num.
REQ-034 Preload grant_cnt to 16'hFFFF via 65535 grants, then one more grant -> grant_cnt=0.
REQ-035 Assert reset_reset_n low while ack=0010 -> ack, rnd_out, and ready go 0 asynchronously; state returns to SEED.

Source files
------------

// File: rtl/rng_arbiter_pkg.sv
// Shared definitions for the random-number arbiter: FSM states, LFSR constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package rng_arbiter_pkg;

   typedef enum logic {
      ST_SEED = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   // One Galois step: shift right, fold the feedback taps in when a one falls out.
   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
   endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Round-robin picker: first set bit of eligible at or after ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: none; valid low when nothing is eligible.
// Ports: eligible (request mask), ptr (search start) -> valid, index (winner).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [PW-1:0]    ptr,
   output logic             valid,
   output logic [PW-1:0]    index
);

   int j;

   always_comb begin
      valid = 1'b0;
      index = '0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!valid && eligible[j]) begin
            valid = 1'b1;
            index = PW'(j);
         end
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out one-cycle grants tagged with an LFSR-derived random word.
// Latency: one cycle from req sampled high (in RUN) to ack; at most one grant per cycle.
// Backpressure: requests are level-held; none are served until a seed arrives or SEED times out.
// Ports: clk_clk, reset_reset_n, random_num (seed word), req -> ack, rnd_out, ready, grant_cnt.
module rng_arbiter
   import rng_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int SEED_TIMEOUT = 256
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [31:0]      random_num,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] ack,
   output logic [31:0]      rnd_out,
   output logic             ready,
   output logic [15:0]      grant_cnt
);

   localparam int PW = $clog2(N_REQ);

   state_t           state;
   logic [31:0]      lfsr;
   logic [31:0]      prev_seed;
   logic [15:0]      wait_cnt;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    pick_idx;
   logic             pick_vld;
   logic             reseed;
   logic [N_REQ-1:0] eligible;

   // Any change in the software-written word counts as a new seed.
   assign reseed = (random_num != prev_seed);

   // Mask the requester acked this cycle: its req is still high while it sees the ack.
   assign eligible = (state == ST_RUN) ? (req & ~ack) : '0;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .valid    (pick_vld),
      .index    (pick_idx)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state     <= ST_SEED;
         ack       <= '0;
         rnd_out   <= '0;
         ready     <= 1'b0;
         grant_cnt <= '0;
         ptr       <= '0;
         wait_cnt  <= '0;
         lfsr      <= DEFAULT_SEED;
         prev_seed <= '0;
      end else begin
         prev_seed <= random_num;

         // A zero seed would lock the LFSR, so substitute the default.
         if (reseed)
            lfsr <= (random_num == 32'h0) ? DEFAULT_SEED : random_num;
         else
            lfsr <= lfsr_step(lfsr);

         if (state == ST_SEED) begin
            ack <= '0;
            if ((reseed && random_num != 32'h0) ||
                (wait_cnt == 16'(SEED_TIMEOUT - 1))) begin
               state <= ST_RUN;
               ready <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 16'd1;
            end
         end else begin
            if (pick_vld) begin
               ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
               // Uses the pre-reseed lfsr even when a reseed lands this cycle.
               rnd_out   <= lfsr ^ random_num;
               ptr       <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               grant_cnt <= grant_cnt + 16'd1;
            end else begin
               ack <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter against a behavioural reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rng_arbiter;

   localparam int N = 4;

   logic         clk_clk = 1'b0;
   logic         reset_reset_n = 1'b0;
   logic [31:0]  random_num = 32'h0;
   logic [N-1:0] req = '0;
   logic [N-1:0] ack;
   logic [31:0]  rnd_out;
   logic         ready;
   logic [15:0]  grant_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0]  m_lfsr, m_prev, m_rnd;
   logic [N-1:0] m_ack;
   logic [15:0]  m_cnt;
   logic         m_run;
   int           m_wait, m_ptr;

   rng_arbiter #(.N_REQ(N), .SEED_TIMEOUT(256)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .random_num    (random_num),
      .req           (req),
      .ack           (ack),
      .rnd_out       (rnd_out),
      .ready         (ready),
      .grant_cnt     (grant_cnt)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic model_reset();
      m_lfsr = 32'hACE1_2468; m_prev = 32'h0; m_rnd = 32'h0;
      m_ack = '0; m_cnt = 16'h0; m_run = 1'b0; m_wait = 0; m_ptr = 0;
   endtask

   // Advance one clock; the model updates from the inputs held across the edge.
   task automatic tick();
      logic [N-1:0] elig;
      logic [31:0]  nxt;
      int           win;
      @(posedge clk_clk);
      elig = m_run ? (req & ~m_ack) : '0;
      win = -1;
      for (int k = 0; k < N; k++)
         if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (random_num != m_prev)
         nxt = (random_num == 32'h0) ? 32'hACE1_2468 : random_num;
      else
         nxt = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
      if (!m_run) begin
         m_ack = '0;
         if ((random_num != m_prev && random_num != 32'h0) || m_wait == 255) m_run = 1'b1;
         else m_wait++;
      end else if (win >= 0) begin
         m_ack = N'(1) << win;
         m_rnd = m_lfsr ^ random_num;
         m_ptr = (win + 1) % N;
         m_cnt = m_cnt + 16'd1;
      end else begin
         m_ack = '0;
      end
      m_lfsr = nxt;
      m_prev = random_num;
      #1;
   endtask

   task automatic apply_reset(input logic [31:0] rn);
      reset_reset_n = 1'b0;
      random_num = rn;
      req = '0;
      model_reset();
      repeat (2) @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
      checks++; if (rnd_out !== 32'h0) begin errors++; $display("FAIL reset_rnd got %h want 0", rnd_out); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
      checks++; if (grant_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", grant_cnt); end
   endtask

   task automatic test_seed_timeout();
      int n;
      n = 0;
      apply_reset(32'h0);
      req = 4'b1111;
      for (int i = 0; i < 300; i++) begin
         tick();
         n++;
         checks++;
         if (ack !== '0 || ready !== m_run) begin
            errors++;
            $display("FAIL seed_wait cyc %0d ack %b ready %b want ack 0 ready %b", n, ack, ready, m_run);
         end
         if (ready === 1'b1) break;
      end
      req = '0;
      checks++; if (n != 256) begin errors++; $display("FAIL seed_timeout ready after %0d cycles want 256", n); end
   endtask

   task automatic test_reseed();
      apply_reset(32'h0);
      repeat (5) tick();
      random_num = 32'h1234_5678;
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reseed_ready got %b want 1", ready); end
      // Grant and reseed together: lfsr here is the freshly loaded seed.
      random_num = 32'hFFFF_0000;
      req = 4'b0001;
      tick();
      req = '0;
      checks++;
      if (ack !== 4'b0001 || rnd_out !== 32'hEDCB_5678 || rnd_out !== m_rnd) begin
         errors++;
         $display("FAIL reseed_grant ack %b rnd %h want ack 0001 rnd edcb5678", ack, rnd_out);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset(32'h0BAD_CAFE);
      tick();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ack !== exp_seq[i] || grant_cnt !== 16'(i + 1)) begin
            errors++;
            $display("FAIL rr_seq step %0d ack %b cnt %0d want %b cnt %0d", i, ack, grant_cnt, exp_seq[i], i + 1);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_single_req();
      random_num = $urandom;
      req = 4'b0100;
      tick();
      req = '0;
      checks++;
      if (ack !== 4'b0100 || rnd_out !== m_rnd) begin
         errors++;
         $display("FAIL single_grant ack %b rnd %h want 0100 rnd %h", ack, rnd_out, m_rnd);
      end
      tick();
      checks++;
      if (ack !== '0 || rnd_out !== m_rnd) begin
         errors++;
         $display("FAIL single_after ack %b rnd %h want 0000 rnd %h", ack, rnd_out, m_rnd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         req = 4'($urandom);
         if ($urandom_range(0, 7) == 0)
            random_num = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         tick();
         checks++;
         if (ack !== m_ack || rnd_out !== m_rnd || grant_cnt !== m_cnt ||
             ready !== m_run || $countones(ack) > 1) begin
            errors++;
            $display("FAIL random cyc %0d ack %b rnd %h cnt %h rdy %b want %b %h %h %b",
                     i, ack, rnd_out, grant_cnt, ready, m_ack, m_rnd, m_cnt, m_run);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_cnt_wrap();
      apply_reset(32'h5555_AAAA);
      tick();
      req = 4'b1111;
      repeat (65535) tick();
      checks++;
      if (grant_cnt !== 16'hFFFF || grant_cnt !== m_cnt) begin
         errors++;
         $display("FAIL cnt_ffff got %h want ffff", grant_cnt);
      end
      tick();
      req = '0;
      checks++; if (grant_cnt !== 16'h0) begin errors++; $display("FAIL cnt_wrap got %h want 0", grant_cnt); end
   endtask

   task automatic test_reset_mid_grant();
      apply_reset(32'h0000_0077);
      tick();
      req = 4'b0010;
      tick();
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL mid_pre ack %b want 0010", ack); end
      #2;
      reset_reset_n = 1'b0;
      random_num = 32'h0;
      model_reset();
      #1;
      checks++;
      if (ack !== '0 || rnd_out !== 32'h0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_async ack %b rnd %h ready %b want 0", ack, rnd_out, ready);
      end
      @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (ack !== '0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_seed cyc %0d ack %b ready %b want 0 0", i, ack, ready);
         end
      end
      req = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_seed_timeout();
      test_reseed();
      test_round_robin();
      test_single_req();
      test_random();
      test_reset_mid_grant();
      test_cnt_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
